// File: rtl/trace_pair_emitter.sv
// trace_pair_emitter
//   Pairs consecutive retired-instruction records onto a two-lane trace port.
//   A non-trap record is held until a partner arrives. It is emitted alone
//   instead when flush is seen, when TIMEOUT idle cycles pass, or, for a trap
//   record arriving while nothing is held, immediately.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_EMPTY | hold register empty; next non-trap record is captured
//   S_HELD  | one record held, waiting for a partner, flush or timeout
//
// Ports
//   clock, reset          : single clock, synchronous active-high reset
//   in_valid / in_ready   : record handshake; in_ready = !out_stall
//   in_*                  : record fields (iaddr, insn, exception, interrupt,
//                           cause, has_wdata, wdata, priv)
//   out_stall             : consumer throttle; freezes the emitter
//   flush                 : forces a held record out alone
//   cycle                 : cycle-counter value at the emitting edge
//   hartid                : constant HARTID
//   trace_0_* / trace_1_* : registered output lanes (lane 0 = older record)
module trace_pair_emitter #(
  parameter logic [63:0] HARTID  = 64'd0,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_iaddr,
  input  logic [31:0] in_insn,
  input  logic        in_exception,
  input  logic        in_interrupt,
  input  logic [63:0] in_cause,
  input  logic        in_has_wdata,
  input  logic [63:0] in_wdata,
  input  logic [2:0]  in_priv,
  input  logic        out_stall,
  input  logic        flush,
  output logic [63:0] cycle,
  output logic [63:0] hartid,
  output logic        trace_0_valid,
  output logic [63:0] trace_0_iaddr,
  output logic [31:0] trace_0_insn,
  output logic        trace_0_exception,
  output logic        trace_0_interrupt,
  output logic [63:0] trace_0_cause,
  output logic        trace_0_has_wdata,
  output logic [63:0] trace_0_wdata,
  output logic [2:0]  trace_0_priv,
  output logic        trace_1_valid,
  output logic [63:0] trace_1_iaddr,
  output logic [31:0] trace_1_insn,
  output logic        trace_1_exception,
  output logic        trace_1_interrupt,
  output logic [63:0] trace_1_cause,
  output logic        trace_1_has_wdata,
  output logic [63:0] trace_1_wdata,
  output logic [2:0]  trace_1_priv
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic {S_EMPTY, S_HELD} state_t;

  typedef struct packed {
    logic [63:0] iaddr;
    logic [31:0] insn;
    logic        exception;
    logic        interrupt;
    logic [63:0] cause;
    logic        has_wdata;
    logic [63:0] wdata;
    logic [2:0]  priv;
  } rec_t;

  rec_t in_rec;
  logic accept;
  logic is_trap;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  rec_t              hold_q, hold_d;
  logic [63:0]       cnt_q, cnt_d;
  logic [63:0]       cycle_q, cycle_d;
  logic              v0_q, v0_d;
  logic              v1_q, v1_d;
  rec_t              lane0_q, lane0_d;
  rec_t              lane1_q, lane1_d;

  assign in_rec = '{iaddr: in_iaddr, insn: in_insn, exception: in_exception,
                    interrupt: in_interrupt, cause: in_cause,
                    has_wdata: in_has_wdata, wdata: in_wdata, priv: in_priv};

  assign in_ready = !out_stall;
  assign accept   = in_valid && !out_stall;
  assign is_trap  = in_exception || in_interrupt;

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q + 64'd1;
    cycle_d = cnt_q;
    v0_d    = 1'b0;
    v1_d    = 1'b0;
    // Invalid lanes keep their old contents to avoid needless toggling.
    lane0_d = lane0_q;
    lane1_d = lane1_q;

    if (!out_stall) begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            if (is_trap) begin
              v0_d    = 1'b1;
              lane0_d = in_rec;
            end else begin
              hold_d  = in_rec;
              wait_d  = '0;
              state_d = S_HELD;
            end
          end
        end
        S_HELD: begin
          if (accept) begin
            v0_d    = 1'b1;
            lane0_d = hold_q;
            v1_d    = 1'b1;
            lane1_d = in_rec;
            state_d = S_EMPTY;
          end else if (flush || (wait_q == WAIT_LAST)) begin
            v0_d    = 1'b1;
            lane0_d = hold_q;
            state_d = S_EMPTY;
          end else begin
            wait_d = wait_q + WAIT_W'(1);
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_EMPTY;
      wait_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      cycle_q <= '0;
      v0_q    <= 1'b0;
      v1_q    <= 1'b0;
      lane0_q <= '0;
      lane1_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      cycle_q <= cycle_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
    end
  end

  assign cycle  = cycle_q;
  assign hartid = HARTID;

  assign trace_0_valid     = v0_q;
  assign trace_0_iaddr     = lane0_q.iaddr;
  assign trace_0_insn      = lane0_q.insn;
  assign trace_0_exception = lane0_q.exception;
  assign trace_0_interrupt = lane0_q.interrupt;
  assign trace_0_cause     = lane0_q.cause;
  assign trace_0_has_wdata = lane0_q.has_wdata;
  assign trace_0_wdata     = lane0_q.wdata;
  assign trace_0_priv      = lane0_q.priv;

  assign trace_1_valid     = v1_q;
  assign trace_1_iaddr     = lane1_q.iaddr;
  assign trace_1_insn      = lane1_q.insn;
  assign trace_1_exception = lane1_q.exception;
  assign trace_1_interrupt = lane1_q.interrupt;
  assign trace_1_cause     = lane1_q.cause;
  assign trace_1_has_wdata = lane1_q.has_wdata;
  assign trace_1_wdata     = lane1_q.wdata;
  assign trace_1_priv      = lane1_q.priv;

endmodule
